// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: load, clear, logical/arithmetic/rotate shifts, one bit per cycle.
// Optional even-parity output is compiled in when USR_PARITY_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; single-step ops complete here
// RUN   | multi-bit shift in progress, one bit step per edge
module univ_shift_reg #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   input  logic [WIDTH-1:0] in,
   input  logic             sl_in,
   input  logic             sr_in,
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
`ifdef USR_PARITY_EN
   output logic             parity,
`endif
   output logic             done
);

   localparam logic [2:0] M_HOLD = 3'b000;
   localparam logic [2:0] M_LOAD = 3'b001;
   localparam logic [2:0] M_SHL  = 3'b010;
   localparam logic [2:0] M_SHR  = 3'b011;
   localparam logic [2:0] M_ROL  = 3'b100;
   localparam logic [2:0] M_ROR  = 3'b101;
   localparam logic [2:0] M_ASR  = 3'b110;
   localparam logic [2:0] M_CLR  = 3'b111;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [2:0]       mode_r;
   logic [AMT_W-1:0] remaining;
   logic             fin;

   function automatic logic [WIDTH-1:0] bit_step(input logic [2:0] m, input logic [WIDTH-1:0] v,
                                                 input logic sl, input logic sr);
      logic [WIDTH-1:0] r;
      r = v;
      case (m)
         M_SHL:   r = {v[WIDTH-2:0], sl};
         M_SHR:   r = {sr, v[WIDTH-1:1]};
         M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
         M_ROR:   r = {v[0], v[WIDTH-1:1]};
         M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // fin marks the edge an op completes; done follows it one cycle later
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         q         <= '0;
         mode_r    <= M_HOLD;
         remaining <= '0;
         fin       <= 1'b0;
         done      <= 1'b0;
         busy      <= 1'b0;
      end else begin
         done <= fin;
         fin  <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mode_r <= mode;
                  case (mode)
                     M_HOLD: fin <= 1'b1;
                     M_LOAD: begin
                        q   <= in;
                        fin <= 1'b1;
                     end
                     M_CLR: begin
                        q   <= '0;
                        fin <= 1'b1;
                     end
                     default: begin
                        if (amt == '0) begin
                           fin <= 1'b1;
                        end else begin
                           q <= bit_step(mode, q, sl_in, sr_in);
                           remaining <= amt - 1'b1;
                           if (amt == AMT_W'(1)) begin
                              fin <= 1'b1;
                           end else begin
                              state <= RUN;
                              busy  <= 1'b1;
                           end
                        end
                     end
                  endcase
               end
            end
            RUN: begin
               q         <= bit_step(mode_r, q, sl_in, sr_in);
               remaining <= remaining - 1'b1;
               if (remaining == AMT_W'(1)) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  fin   <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign so_l = q[WIDTH-1];
   assign so_r = q[0];

`ifdef USR_PARITY_EN
   assign parity = ^q;
`endif

endmodule
